// File: rtl/filter_status_pio.sv
// filter_status_pio: Avalon-MM input PIO for external filter status flags.
// Synchronises in_port, detects per-bit edges into a sticky edge-capture
// register, and raises a maskable level interrupt.
module filter_status_pio #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q, sync_chain_d;
  logic [WIDTH-1:0]                  sync_q;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [WIDTH-1:0]                  irqmask_q, irqmask_d;
  logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
  logic [31:0]                       readdata_q, readdata_d;

  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] rd_sel;
  logic [WIDTH-1:0] irq_src;
  logic             wr_en;

  // Upper writedata bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign sync_q = sync_chain_q[SYNC_STAGES-1];
  assign wr_en  = chipselect & ~write_n;

  // Shift in_port through the synchroniser chain; delay sync_q by one for edge detect.
  always_comb begin
    sync_chain_d    = sync_chain_q;
    sync_chain_d[0] = in_port;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_chain_d[i] = sync_chain_q[i-1];
    end
    prev_d = sync_q;
  end

  // Per-bit edge detection selected by EDGE_TYPE.
  always_comb begin
    edge_det = '0;
    if (EDGE_TYPE == 0) begin
      edge_det = sync_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~sync_q & prev_q;
    end else begin
      edge_det = sync_q ^ prev_q;
    end
  end

  // Register writes: mask load and write-1-to-clear capture; a new edge beats a clear.
  always_comb begin
    irqmask_d = irqmask_q;
    clr_bits  = '0;
    if (wr_en && address == 2'd2) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd3) begin
      clr_bits = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clr_bits) | edge_det;
  end

  // Read mux, registered every cycle for a fixed latency of one.
  always_comb begin
    rd_sel = '0;
    case (address)
      2'd0:    rd_sel = sync_q;
      2'd1:    rd_sel = '0;
      2'd2:    rd_sel = irqmask_q;
      default: rd_sel = edgecap_q;
    endcase
    readdata_d = 32'(rd_sel);
  end

  // All state clears asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain_q <= '0;
      prev_q       <= '0;
      irqmask_q    <= '0;
      edgecap_q    <= '0;
      readdata_q   <= '0;
    end else begin
      sync_chain_q <= sync_chain_d;
      prev_q       <= prev_d;
      irqmask_q    <= irqmask_d;
      edgecap_q    <= edgecap_d;
      readdata_q   <= readdata_d;
    end
  end

  // Interrupt source is either the sticky captures or the live synced level.
  always_comb begin
    irq_src = (IRQ_MODE == 1) ? edgecap_q : sync_q;
    irq     = |(irq_src & irqmask_q);
  end

  assign readdata = readdata_q;

endmodule
